knight_rider_monitor: RTL and testbench

Receive-side checker for the 10-LED sweep display. It samples an N-bit LED pattern bus, encodes the lit LED back to an index, and tracks sweep direction. It counts end-of-bar bounces and flags any pattern that breaks the sweep protocol (multi-lit, skipped LED, mid-bar reversal, stall). It sits beside the flasher on the board and feeds status LEDs and HEX displays, or runs in a bench against the flasher output.

---
 rtl/knight_rider_monitor.sv | 185 ++++++++++++++++++
 tb/tb_knight_rider_monitor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knight_rider_monitor.sv
// Receive-side checker for a one-hot LED sweep bar: tracks position/direction, counts bounces, flags protocol faults.
// Latency: a pattern stable before edge k is reflected on the outputs after edge k+2 (two sync flops, one decision stage).
// Backpressure: none; this block only observes the bus and never stalls the flasher.
module knight_rider_monitor #(
    parameter int N         = 10,
    parameter int W         = 4,
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 50000000
) (
    input  logic             Clock50,
    input  logic             Reset,
    input  logic [N-1:0]     LEDRArray,
    output logic [W-1:0]     Position,
    output logic             Valid,
    output logic             Direction,
    output logic             StepPulse,
    output logic [CNT_W-1:0] SweepCount,
    output logic             Stalled,
    output logic             Error,
    output logic [1:0]       ErrorCode
);
    localparam int              SC_W      = $clog2(STALL_MAX + 1);
    localparam logic [SC_W-1:0] STALL_LIM = SC_W'(STALL_MAX);
    localparam logic [W-1:0]    LAST_IDX  = W'(N - 1);

    localparam logic [1:0] EC_NONE  = 2'b00;
    localparam logic [1:0] EC_MULTI = 2'b01;
    localparam logic [1:0] EC_JUMP  = 2'b10;
    localparam logic [1:0] EC_REV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      sync1_q, sync2_q, prev_q;
    logic [SC_W-1:0]   stall_cnt_q, stall_d;
    logic              dir_known_q, dk_d;

    logic [W-1:0]      pos_d;
    logic              dir_d, valid_d, step_d, stalled_d, err_d;
    logic [CNT_W-1:0]  sweep_d;
    logic [1:0]        code_d;

    logic              s_zero, s_onehot, s_multi, s_same;
    logic [W-1:0]      s_idx;
    logic [W:0]        idx_x, pos_x;
    logic              step_up, step_dn, new_dir;

    // Sample decode: lit-count class and the index of the (highest) lit LED.
    always_comb begin
        s_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sync2_q[i]) s_idx = W'(i);
        end
    end

    assign s_zero   = (sync2_q == '0);
    assign s_onehot = !s_zero && ((sync2_q & (sync2_q - N'(1))) == '0);
    assign s_multi  = !s_zero && !s_onehot;
    assign s_same   = (sync2_q == prev_q);

    // Neighbour test done one bit wider so Position+1 cannot wrap.
    assign idx_x    = {1'b0, s_idx};
    assign pos_x    = {1'b0, Position};
    assign step_up  = (idx_x == pos_x + (W+1)'(1));
    assign step_dn  = (pos_x == idx_x + (W+1)'(1));
    assign new_dir  = step_dn;

    always_comb begin
        state_d   = state_q;
        pos_d     = Position;
        dir_d     = Direction;
        dk_d      = dir_known_q;
        sweep_d   = SweepCount;
        stall_d   = stall_cnt_q;
        stalled_d = Stalled;
        step_d    = 1'b0;
        err_d     = Error;
        code_d    = ErrorCode;

        unique case (state_q)
            IDLE: begin
                stall_d   = '0;
                stalled_d = 1'b0;
                if (s_onehot) begin
                    state_d = TRACK;
                    pos_d   = s_idx;
                    dk_d    = 1'b0;
                end else if (s_multi) begin
                    state_d = FAULT;
                    err_d   = 1'b1;
                    code_d  = EC_MULTI;
                end
            end

            TRACK: begin
                if (s_same) begin
                    if (stall_cnt_q != STALL_LIM) stall_d = stall_cnt_q + SC_W'(1);
                    stalled_d = (stall_d == STALL_LIM);
                end else begin
                    stall_d   = '0;
                    stalled_d = 1'b0;
                    if (s_zero) begin
                        state_d = IDLE;
                    end else if (s_multi) begin
                        state_d = FAULT;
                        err_d   = 1'b1;
                        code_d  = EC_MULTI;
                    end else if (step_up || step_dn) begin
                        if (!dir_known_q || (new_dir == Direction)) begin
                            step_d = 1'b1;
                            pos_d  = s_idx;
                            dir_d  = new_dir;
                            dk_d   = 1'b1;
                        end else if ((Position == '0) || (Position == LAST_IDX)) begin
                            step_d = 1'b1;
                            pos_d  = s_idx;
                            dir_d  = new_dir;
                            dk_d   = 1'b1;
                            if (SweepCount != '1) sweep_d = SweepCount + CNT_W'(1);
                        end else begin
                            state_d = FAULT;
                            err_d   = 1'b1;
                            code_d  = EC_REV;
                        end
                    end else if (s_idx != Position) begin
                        // Includes the N-1 <-> 0 wrap: the bar is linear, not circular.
                        state_d = FAULT;
                        err_d   = 1'b1;
                        code_d  = EC_JUMP;
                    end
                end
            end

            FAULT: begin
                stall_d   = '0;
                stalled_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == TRACK);
    end

    always_ff @(posedge Clock50) begin
        if (Reset) begin
            state_q     <= IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            stall_cnt_q <= '0;
            dir_known_q <= 1'b0;
            Position    <= '0;
            Valid       <= 1'b0;
            Direction   <= 1'b0;
            StepPulse   <= 1'b0;
            SweepCount  <= '0;
            Stalled     <= 1'b0;
            Error       <= 1'b0;
            ErrorCode   <= EC_NONE;
        end else begin
            state_q     <= state_d;
            sync1_q     <= LEDRArray;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            stall_cnt_q <= stall_d;
            dir_known_q <= dk_d;
            Position    <= pos_d;
            Valid       <= valid_d;
            Direction   <= dir_d;
            StepPulse   <= step_d;
            SweepCount  <= sweep_d;
            Stalled     <= stalled_d;
            Error       <= err_d;
            ErrorCode   <= code_d;
        end
    end

endmodule

// File: tb/tb_knight_rider_monitor.sv
// Bench for knight_rider_monitor: directed vector table, hand-written corner sequences, random walk vs reference model.
module tb_knight_rider_monitor;
    localparam int N         = 10;
    localparam int W         = 4;
    localparam int CNT_W     = 16;
    localparam int STALL_MAX = 8;

    localparam int M_IDLE  = 0;
    localparam int M_TRACK = 1;
    localparam int M_FAULT = 2;

    logic             Clock50 = 1'b0;
    logic             Reset;
    logic [N-1:0]     LEDRArray;
    logic [W-1:0]     Position;
    logic             Valid;
    logic             Direction;
    logic             StepPulse;
    logic [CNT_W-1:0] SweepCount;
    logic             Stalled;
    logic             Error;
    logic [1:0]       ErrorCode;

    knight_rider_monitor #(
        .N(N), .W(W), .CNT_W(CNT_W), .STALL_MAX(STALL_MAX)
    ) dut (
        .Clock50(Clock50),
        .Reset(Reset),
        .LEDRArray(LEDRArray),
        .Position(Position),
        .Valid(Valid),
        .Direction(Direction),
        .StepPulse(StepPulse),
        .SweepCount(SweepCount),
        .Stalled(Stalled),
        .Error(Error),
        .ErrorCode(ErrorCode)
    );

    always #5 Clock50 = ~Clock50;

    int errors = 0;
    int checks = 0;
    int step_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: integer bookkeeping of the sweep rules plus a two-deep input delay line.
    bit           m_known = 1'b0;
    int           m_state, m_pos, m_dir, m_dk, m_sweep, m_stall;
    int           m_stalled, m_err, m_code, m_valid, m_step;
    logic [N-1:0] m_s1, m_s2, m_prev;

    function automatic void m_fault(input int c);
        if (m_err == 0) begin
            m_err  = 1;
            m_code = c;
        end
        m_state = M_FAULT;
    endfunction

    task automatic model_edge(input logic rst, input logic [N-1:0] pat);
        logic [N-1:0] s;
        int ones, idx, d, nd;
        if (rst) begin
            m_known = 1'b1;
            m_state = M_IDLE; m_pos = 0; m_dir = 0; m_dk = 0; m_sweep = 0; m_stall = 0;
            m_stalled = 0; m_err = 0; m_code = 0; m_valid = 0; m_step = 0;
            m_s1 = '0; m_s2 = '0; m_prev = '0;
            return;
        end
        s      = m_s2;
        m_step = 0;
        ones   = $countones(s);
        idx    = 0;
        for (int i = 0; i < N; i++) if (s[i]) idx = i;
        case (m_state)
            M_IDLE: begin
                m_stall = 0; m_stalled = 0;
                if (ones == 1) begin
                    m_state = M_TRACK; m_pos = idx; m_dk = 0;
                end else if (ones > 1) begin
                    m_fault(1);
                end
            end
            M_TRACK: begin
                if (s == m_prev) begin
                    if (m_stall < STALL_MAX) m_stall++;
                    if (m_stall >= STALL_MAX) m_stalled = 1;
                end else begin
                    m_stall = 0; m_stalled = 0;
                    d = idx - m_pos;
                    if (ones == 0) m_state = M_IDLE;
                    else if (ones > 1) m_fault(1);
                    else if (d > 1 || d < -1) m_fault(2);
                    else if (d != 0) begin
                        nd = (d < 0) ? 1 : 0;
                        if (m_dk == 0 || nd == m_dir) begin
                            m_step = 1; m_pos = idx; m_dir = nd; m_dk = 1;
                        end else if (m_pos == 0 || m_pos == N - 1) begin
                            m_step = 1; m_pos = idx; m_dir = nd; m_dk = 1;
                            if (m_sweep < (1 << CNT_W) - 1) m_sweep++;
                        end else begin
                            m_fault(3);
                        end
                    end
                end
            end
            default: m_stalled = 0;
        endcase
        m_valid = (m_state == M_TRACK) ? 1 : 0;
        m_prev  = m_s2;
        m_s2    = m_s1;
        m_s1    = pat;
    endtask

    task automatic compare_model();
        check("model_position",    Position,   m_pos);
        check("model_valid",       Valid,      m_valid);
        check("model_direction",   Direction,  m_dir);
        check("model_step_pulse",  StepPulse,  m_step);
        check("model_sweep_count", SweepCount, m_sweep);
        check("model_stalled",     Stalled,    m_stalled);
        check("model_error",       Error,      m_err);
        check("model_error_code",  ErrorCode,  m_code);
    endtask

    // One clock: drive, advance the model, sample 1 time unit after the edge.
    task automatic tick(input logic rst, input logic [N-1:0] pat);
        Reset     = rst;
        LEDRArray = pat;
        model_edge(rst, pat);
        @(posedge Clock50);
        #1;
        if (m_known) compare_model();
        if (StepPulse === 1'b1) step_seen++;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] pat;
        int           hold;
        int           pos, valid, dir, sweep, err, code, steps;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit rst, input int pat, input int hold, input int pos,
                                input int valid, input int dir, input int sweep,
                                input int err, input int code, input int steps);
        vec_t v;
        v.rst = rst; v.pat = N'(pat); v.hold = hold;
        v.pos = pos; v.valid = valid; v.dir = dir; v.sweep = sweep;
        v.err = err; v.code = code; v.steps = steps;
        tbl.push_back(v);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur, dir_up, r, hold, a, b;
        logic rst_b;
        logic [N-1:0] p;

        Reset = 1'b1;
        LEDRArray = '0;

        // rst, pattern, hold, Position, Valid, Direction, SweepCount, Error, ErrorCode, StepPulses in hold
        add(1, 0, 2,    0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 10,   0, 0, 0, 0, 0, 0, 0);
        add(0, 'h001, 4, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i < N; i++)       add(0, 1 << i, 4, i, 1, 0, 0, 0, 0, 1);
        for (int i = N - 2; i >= 0; i--)  add(0, 1 << i, 4, i, 1, 1, 1, 0, 0, 1);
        add(0, 'h002, 4, 1, 1, 0, 2, 0, 0, 1);
        add(0, 0,     4, 1, 0, 0, 2, 0, 0, 0);
        add(0, 'h100, 4, 8, 1, 0, 2, 0, 0, 0);
        add(0, 'h080, 4, 7, 1, 1, 2, 0, 0, 1);
        add(1, 0,     2, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h001, 4, 0, 1, 0, 0, 0, 0, 0);
        add(0, 'h002, 4, 1, 1, 0, 0, 0, 0, 1);
        add(0, 'h004, 4, 2, 1, 0, 0, 0, 0, 1);
        add(0, 'h008, 4, 3, 1, 0, 0, 0, 0, 1);
        add(0, 'h020, 4, 3, 0, 0, 0, 1, 2, 0);
        add(1, 0,     2, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h001, 4, 0, 1, 0, 0, 0, 0, 0);
        add(0, 'h200, 4, 0, 0, 0, 0, 1, 2, 0);
        add(1, 0,     2, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h003, 4, 0, 0, 0, 0, 1, 1, 0);
        add(1, 0,     2, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h001, 4, 0, 1, 0, 0, 0, 0, 0);
        add(0, 'h002, 4, 1, 1, 0, 0, 0, 0, 1);
        add(0, 'h018, 4, 1, 0, 0, 0, 1, 1, 0);
        add(1, 0,     1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h008, 4, 3, 1, 0, 0, 0, 0, 0);
        add(0, 'h010, 4, 4, 1, 0, 0, 0, 0, 1);
        add(0, 'h020, 4, 5, 1, 0, 0, 0, 0, 1);
        add(0, 'h010, 4, 5, 0, 0, 0, 1, 3, 0);
        add(1, 0,     2, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step_seen = 0;
            for (int h = 0; h < tbl[i].hold; h++) tick(tbl[i].rst, tbl[i].pat);
            check($sformatf("tbl%0d_position", i),   Position,   tbl[i].pos);
            check($sformatf("tbl%0d_valid", i),      Valid,      tbl[i].valid);
            check($sformatf("tbl%0d_direction", i),  Direction,  tbl[i].dir);
            check($sformatf("tbl%0d_sweep", i),      SweepCount, tbl[i].sweep);
            check($sformatf("tbl%0d_error", i),      Error,      tbl[i].err);
            check($sformatf("tbl%0d_error_code", i), ErrorCode,  tbl[i].code);
            check($sformatf("tbl%0d_steps", i),      step_seen,  tbl[i].steps);
        end

        // Multi-lit latency: fault visible on the third edge after the pattern is driven.
        for (int h = 0; h < 4; h++) tick(0, 10'h001);
        for (int h = 0; h < 4; h++) tick(0, 10'h002);
        for (int i = 1; i <= 4; i++) begin
            tick(0, 10'h018);
            check($sformatf("multi_lat%0d_error", i), Error,     (i >= 3) ? 1 : 0);
            check($sformatf("multi_lat%0d_code", i),  ErrorCode, (i >= 3) ? 1 : 0);
        end
        tick(1, '0);
        check("reset_after_fault_error", Error, 0);
        check("reset_after_fault_valid", Valid, 0);

        // Stall: 8 unchanged cycles in TRACK raise Stalled, next legal step clears it.
        tick(1, '0);
        for (int h = 0; h < 4; h++) tick(0, 10'h008);
        for (int i = 1; i <= 12; i++) begin
            tick(0, 10'h010);
            check($sformatf("stall_ramp%0d", i), Stalled, (i >= 11) ? 1 : 0);
        end
        step_seen = 0;
        for (int i = 1; i <= 4; i++) begin
            tick(0, 10'h020);
            check($sformatf("stall_exit%0d_stalled", i), Stalled, (i < 3) ? 1 : 0);
        end
        check("stall_exit_steps", step_seen, 1);
        check("stall_exit_position", Position, 5);

        // Random walk with occasional off, multi-lit, jump, reversal, long hold and reset.
        cur = 0;
        dir_up = 1;
        tick(1, '0);
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 99);
            hold = $urandom_range(1, 4);
            rst_b = 1'b0;
            p = '0;
            if (r < 5) begin
                rst_b = 1'b1;
                hold = 1;
            end else if (r < 7) begin
                p = '0;
            end else if (r < 9) begin
                a = $urandom_range(0, N - 1);
                b = (a + 1 + $urandom_range(0, N - 2)) % N;
                p[a] = 1'b1;
                p[b] = 1'b1;
            end else if (r < 11) begin
                cur = $urandom_range(0, N - 1);
                p[cur] = 1'b1;
            end else begin
                if (r < 15) dir_up = 1 - dir_up;
                if (dir_up == 1 && cur == N - 1) dir_up = 0;
                if (dir_up == 0 && cur == 0) dir_up = 1;
                cur = (dir_up == 1) ? cur + 1 : cur - 1;
                p[cur] = 1'b1;
                if (r >= 92) hold = $urandom_range(9, 13);
            end
            for (int h = 0; h < hold; h++) tick(rst_b, p);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
